// File: rtl/div_unit_pkg.sv
// Shared widths, state encoding and sign helper for the iterative divider.
// Imported by div_unit; holds no logic of its own.
package div_unit_pkg;

  localparam int DataBus = 32;
  localparam int DWord   = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic [DataBus-1:0] neg_if(input logic c, input logic [DataBus-1:0] x);
    return c ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 DIV/DIVU: 33 cycles accept->ready (1 cycle for divide by zero).
// No output backpressure; holds the pipeline through stallreq and drops it in the ready cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [DataBus-1:0] opr1,
  input  logic [DataBus-1:0] opr2,
  input  logic               cancel,
  output logic [DWord-1:0]   divres,
  output logic               ready,
  output logic               stallreq
);

  div_state_e         state_q, state_d;
  logic [4:0]         cnt_q;
  logic [DataBus:0]   rem_q;
  logic [DataBus-1:0] dq_q;
  logic [DataBus-1:0] dsr_q;
  logic               sop_q, s1_q, s2_q;
  logic [DWord-1:0]   divres_q;

  logic               accept;
  logic               last;
  logic [DataBus+1:0] trial;
  logic               qbit;
  logic [DataBus:0]   rem_nxt;
  logic [DataBus-1:0] quo_nxt;

  assign accept = (state_q == DIV_IDLE) & start & ~cancel;
  assign last   = (cnt_q == 5'd31);

  // Dividend bits leave dq_q at the top while quotient bits enter at the bottom.
  assign trial   = {rem_q, dq_q[DataBus-1]} - {2'b00, dsr_q};
  assign qbit    = ~trial[DataBus+1];
  assign rem_nxt = qbit ? trial[DataBus:0] : {rem_q[DataBus-1:0], dq_q[DataBus-1]};
  assign quo_nxt = {dq_q[DataBus-2:0], qbit};

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = (opr2 == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (last) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (cancel) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dq_q     <= '0;
      dsr_q    <= '0;
      sop_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      divres_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sop_q <= signed_op;
        s1_q  <= opr1[DataBus-1];
        s2_q  <= opr2[DataBus-1];
        dq_q  <= neg_if(signed_op & opr1[DataBus-1], opr1);
        dsr_q <= neg_if(signed_op & opr2[DataBus-1], opr2);
        rem_q <= '0;
        cnt_q <= '0;
        if (opr2 == '0) divres_q <= {opr1, {DataBus{1'b1}}};
      end else if ((state_q == DIV_CALC) && !cancel) begin
        rem_q <= rem_nxt;
        dq_q  <= quo_nxt;
        cnt_q <= cnt_q + 5'd1;
        // Remainder follows the dividend sign; quotient negates when signs differ.
        if (last)
          divres_q <= {neg_if(sop_q & s1_q, rem_nxt[DataBus-1:0]),
                       neg_if(sop_q & (s1_q ^ s2_q), quo_nxt)};
      end
    end
  end

  assign divres   = divres_q;
  assign ready    = (state_q == DIV_DONE) & ~cancel & ~rst;
  assign stallreq = start & (state_q != DIV_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized DIV/DIVU
// against an integer-arithmetic reference.
module tb_div_unit;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] opr1 = '0;
  logic [31:0] opr2 = '0;
  logic        cancel = 1'b0;
  logic [63:0] divres;
  logic        ready;
  logic        stallreq;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   in_op = 1'b0;
  exp_t sbq[$];
  exp_t me;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .opr1     (opr1),
    .opr2     (opr2),
    .cancel   (cancel),
    .divres   (divres),
    .ready    (ready),
    .stallreq (stallreq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Truncating division on 64-bit integers; -2^31 / -1 needs no special handling here.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        me = sbq.pop_front();
        chk("divres", divres, me.res);
        chk("latency", 64'(cyc - me.acc), 64'(me.lat));
      end
    end
  end

  // An operation in flight must keep start high unless it is being flushed.
  always @(negedge clk) begin
    if (in_op && !start && !cancel && !rst) begin
      errors++;
      $display("FAIL start_dropped_in_calc: actual=0 expected=1 (cycle %0d)", cyc);
    end
  end

  // Entered and left just after a rising edge.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    exp_t e;
    int   lat, st, k;
    lat       = (b == 0) ? 1 : 33;
    signed_op = sgn;
    opr1      = a;
    opr2      = b;
    start     = 1'b1;
    in_op     = 1'b1;
    e.res = exp;
    e.acc = cyc;
    e.lat = lat;
    sbq.push_back(e);
    st = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stallreq) st++;
      if (ready) break;
    end
    if (k == 40) chk("ready_timeout", 64'd0, 64'd1);
    chk("stall_cycles", 64'(st), 64'(lat));
    @(posedge clk);
    #1;
    start = 1'b0;
    in_op = 1'b0;
    opr1  = $urandom;
    opr2  = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          sgn, saw;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_divres", divres, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stallreq_low", 64'(stallreq), 64'd0);
    start = 1'b1;
    @(negedge clk);
    chk("reset_stallreq_follows_start", 64'(stallreq), 64'd1);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF);
    run_div(1'b0, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF);

    // start with cancel in IDLE: a zero divisor would otherwise be ready next cycle.
    start = 1'b1; cancel = 1'b1; signed_op = 1'b0; opr1 = 32'd5; opr2 = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel_no_accept", 64'(ready), 64'd0);
    @(posedge clk);
    #1;

    // cancel in the DONE cycle of a divide by zero suppresses ready.
    start = 1'b1; signed_op = 1'b1; opr1 = 32'd77; opr2 = 32'd0; in_op = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_in_done_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0; start = 1'b0; in_op = 1'b0;
    @(posedge clk);
    #1;

    // cancel in CALC cycle 10, then a new divide accepted in the very next cycle.
    start = 1'b1; signed_op = 1'b0; opr1 = 32'd1000; opr2 = 32'd3; in_op = 1'b1;
    saw = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) cancel = 1'b1;
      @(negedge clk);
      if (ready) saw = 1'b1;
      @(posedge clk);
      #1;
    end
    cancel = 1'b0;
    in_op  = 1'b0;
    chk("cancel_no_ready", 64'(saw), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // rst in CALC cycle 20 clears every output.
    start = 1'b1; signed_op = 1'b0; opr1 = 32'd1000; opr2 = 32'd7; in_op = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0; start = 1'b0; in_op = 1'b0;
    @(negedge clk);
    chk("rst_divres", divres, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_stallreq", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 30; n++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: begin a = $urandom_range(0, 200); b = 32'hFFFFFFFF - $urandom_range(0, 9); end
        default: ;
      endcase
      run_div(sgn, a, b, model(sgn, a, b));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
